// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address, selects the next PC from
// exception/branch/return/jump/sequential sources, and keeps a circular return-address stack.
module pc_unit #(
  parameter int                    PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0]   EXC_VECTOR   = 32'h0000_0080,
  parameter int                    STEP         = 4,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic                          fetch_ready,
  input  logic                          br_taken,
  input  logic [PC_WIDTH-1:0]           br_target,
  input  logic                          jmp_valid,
  input  logic [PC_WIDTH-1:0]           jmp_target,
  input  logic                          call,
  input  logic                          ret,
  input  logic                          exc,
  output logic [PC_WIDTH-1:0]           pc_out,
  output logic                          pc_valid,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(STEP);
  localparam logic [CW-1:0]       FULL   = CW'(RAS_DEPTH);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       top_q, top_d;
  logic                uf_q, uf_d;
  logic                push;
  logic                advance;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign advance = (state_q == S_RUN) && fetch_ready && !stall;
  assign seq_pc  = pc_q + STEP_W;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    uf_d    = uf_q;
    push    = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (exc) begin
          pc_d    = EXC_VECTOR;
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else if (br_taken) begin
          pc_d = br_target;
        end else if (advance && ret) begin
          if (cnt_q != '0) begin
            pc_d  = ras_mem[top_q];
            cnt_d = cnt_q - 1'b1;
            top_d = top_q - 1'b1;
          end else begin
            pc_d = seq_pc;
            uf_d = 1'b1;
          end
        end else if (advance && jmp_valid) begin
          pc_d = jmp_target;
          if (call) begin
            // A push onto a full stack silently overwrites the oldest slot.
            push  = 1'b1;
            top_d = top_q + 1'b1;
            if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
          end
        end else if (advance) begin
          pc_d = seq_pc;
        end
      end
      S_FLUSH: begin
        if (exc) begin
          pc_d  = EXC_VECTOR;
          cnt_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      top_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      uf_q    <= uf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[top_d] <= seq_pc;
  end

  assign pc_out        = pc_q;
  assign pc_valid      = (state_q == S_RUN);
  assign ras_count     = cnt_q;
  assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random traffic, all
// compared each cycle against a queue-based behavioural model.
module tb_pc_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EV  = 32'h0000_0080;
  localparam int          DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n, stall, fetch_ready, br_taken, jmp_valid, call, ret, exc;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  always #5 clk = ~clk;

  pc_unit #(
    .PC_WIDTH(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .STEP(4), .RAS_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
    .br_taken(br_taken), .br_target(br_target), .jmp_valid(jmp_valid),
    .jmp_target(jmp_target), .call(call), .ret(ret), .exc(exc),
    .pc_out(pc_out), .pc_valid(pc_valid), .ras_count(ras_count),
    .ras_underflow(ras_underflow)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m_pc = RV;
  bit          m_boot  = 1'b1;
  bit          m_flush = 1'b0;
  bit          m_uf    = 1'b0;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    logic adv;
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    adv = fetch_ready && !stall;
    if (!rst_n) begin
      m_pc = RV; m_boot = 1'b1; m_flush = 1'b0; m_uf = 1'b0; m_ras.delete();
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_flush) begin
      if (exc) begin m_pc = EV; m_ras.delete(); end
      else m_flush = 1'b0;
    end else if (exc) begin
      m_pc = EV; m_flush = 1'b1; m_ras.delete();
    end else if (br_taken) begin
      m_pc = br_target;
    end else if (adv && ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = seq; m_uf = 1'b1; end
    end else if (adv && jmp_valid) begin
      if (call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEP) void'(m_ras.pop_front());
      end
      m_pc = jmp_target;
    end else if (adv) begin
      m_pc = seq;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("pc_valid", 32'(pc_valid), 32'(!m_boot && !m_flush));
    chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_uf));
  endtask

  task automatic idle();
    br_taken = 1'b0; jmp_valid = 1'b0; call = 1'b0; ret = 1'b0; exc = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] t);
    br_taken = 1'b1; br_target = t;
    cyc();
    idle();
  endtask

  initial begin
    logic [31:0] pops[4];
    pops[0] = 32'h104; pops[1] = 32'hC4; pops[2] = 32'h84; pops[3] = 32'h44;
    rst_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    br_target = '0; jmp_target = '0;
    idle();

    // reset, boot bubble, sequential fetch
    cyc(); cyc();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", 32'(pc_valid), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("boot_pc0", pc_out, 32'h0);
    chk("boot_valid", 32'(pc_valid), 32'd1);
    cyc(); chk("seq_4", pc_out, 32'h4);
    cyc(); chk("seq_8", pc_out, 32'h8);

    // stall then no handshake
    stall = 1'b1;
    repeat (3) begin cyc(); chk("stall_hold", pc_out, 32'h8); end
    stall = 1'b0; fetch_ready = 1'b0;
    repeat (2) begin cyc(); chk("nordy_hold", pc_out, 32'h8); end
    fetch_ready = 1'b1;
    cyc(); chk("seq_c", pc_out, 32'hC);

    // branch under stall beats jump
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h200;
    jmp_valid = 1'b1; jmp_target = 32'h300;
    cyc(); chk("br_stall", pc_out, 32'h200);
    idle(); stall = 1'b0;

    // call/return chain
    branch_to(32'h10);
    jmp_valid = 1'b1; call = 1'b1; jmp_target = 32'h100; cyc();
    jmp_target = 32'h180; cyc();
    idle();
    chk("chain_cnt", 32'(ras_count), 32'd2);
    ret = 1'b1;
    cyc(); chk("ret1", pc_out, 32'h104);
    cyc(); chk("ret2", pc_out, 32'h14);
    cyc(); chk("ret3", pc_out, 32'h18);
    chk("uf_set", 32'(ras_underflow), 32'd1);
    idle();

    // RAS overflow
    branch_to(32'h0);
    for (int i = 0; i < 5; i++) begin
      jmp_valid = 1'b1; call = 1'b1; jmp_target = 32'((i + 1) * 32'h40);
      cyc();
    end
    idle();
    chk("ovf_cnt", 32'(ras_count), 32'd4);
    ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("ovf_pop", pc_out, pops[i]);
    end
    idle();
    chk("ovf_empty", 32'(ras_count), 32'd0);

    // exception beats branch and return
    branch_to(32'h20);
    jmp_valid = 1'b1; call = 1'b1; jmp_target = 32'h50; cyc();
    idle();
    chk("pre_exc_cnt", 32'(ras_count), 32'd1);
    exc = 1'b1; br_taken = 1'b1; br_target = 32'h999; ret = 1'b1;
    cyc();
    idle();
    chk("exc_pc", pc_out, 32'h80);
    chk("exc_bubble", 32'(pc_valid), 32'd0);
    chk("exc_cnt", 32'(ras_count), 32'd0);
    cyc(); chk("post_exc_pc", pc_out, 32'h80);
    cyc(); chk("post_exc_seq", pc_out, 32'h84);

    // reset mid-flight
    br_taken = 1'b1; br_target = 32'h300; rst_n = 1'b0;
    cyc();
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_valid", 32'(pc_valid), 32'd0);
    idle(); rst_n = 1'b1;
    cyc();

    // wrap-around
    branch_to(32'hFFFF_FFFC);
    cyc(); chk("wrap", pc_out, 32'h0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      rst_n       = ($urandom_range(0, 79) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      exc         = ($urandom_range(0, 29) == 0);
      jmp_valid   = ($urandom_range(0, 2) == 0);
      call        = ($urandom_range(0, 1) == 0);
      ret         = ($urandom_range(0, 4) == 0);
      br_target   = $urandom & 32'hFFFF_FFFC;
      jmp_target  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
